// File: rtl/kfmmc_pkg.sv
// Shared types and defaults for the block sequencer.
// Holds the FSM state encoding and default command bytes.
package kfmmc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR1,
        ADDR2,
        ADDR3,
        ADDR4,
        CMD,
        GUARD,
        WAIT_CMD,
        DATA,
        WAIT_BYTE,
        NEXT,
        FINISH
    } state_t;

    localparam logic [7:0] READ_CMD_DEFAULT  = 8'h80;
    localparam logic [7:0] WRITE_CMD_DEFAULT = 8'h81;

endpackage

// File: rtl/kfmmc_busy_timer.sv
// Busy-wait timer for the block sequencer.
// Counts cycles while enabled and flags when the limit is reached.
module kfmmc_busy_timer #(
    parameter logic [31:0] limit = 32'h00FFFFFF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] cnt_q;

    assign expired = (cnt_q == limit);

    // Cycle counter, held at the limit once reached.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/kfmmc_block_sequencer.sv
// Multi-block read/write sequencer for a byte-wide drive port.
// Sends address and command bytes, then moves block_bytes per block.
module kfmmc_block_sequencer
    import kfmmc_pkg::*;
#(
    parameter int unsigned block_bytes   = 512,
    parameter logic [7:0]  read_command  = READ_CMD_DEFAULT,
    parameter logic [7:0]  write_command = WRITE_CMD_DEFAULT,
    parameter logic [31:0] busy_timeout  = 32'h00FFFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_lba,
    input  logic [7:0]  req_count,
    output logic [7:0]  internal_data_bus,
    output logic        write_block_address_1,
    output logic        write_block_address_2,
    output logic        write_block_address_3,
    output logic        write_block_address_4,
    output logic        write_access_command,
    output logic        write_data,
    output logic        read_data_strobe,
    input  logic [7:0]  read_data,
    input  logic        drive_busy,
    output logic        terminal_count,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        done,
    output logic        error
);

    localparam logic [9:0] BB_N    = 10'(block_bytes);
    localparam logic [9:0] BB_LAST = 10'(block_bytes - 1);

    state_t      state_q;
    logic [31:0] lba_q;
    logic [8:0]  remain_q;
    logic        write_q;
    logic [9:0]  bcnt_q;

    logic in_wait;
    logic expired;
    logic xfer;
    logic last_byte;

    assign in_wait   = (state_q == WAIT_CMD) || (state_q == WAIT_BYTE);
    assign xfer      = (state_q == DATA) && (write_q ? wr_valid : rd_ready);
    assign last_byte = (bcnt_q == BB_LAST) && (remain_q == 9'd1);

    kfmmc_busy_timer #(
        .limit(busy_timeout)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (!in_wait),
        .enable (in_wait),
        .expired(expired)
    );

    // Sequencer state, request latches and byte counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            lba_q    <= '0;
            remain_q <= '0;
            write_q  <= 1'b0;
            bcnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        lba_q    <= req_lba;
                        remain_q <= (req_count == 8'd0) ? 9'd256 : {1'b0, req_count};
                        write_q  <= req_write;
                        bcnt_q   <= '0;
                        state_q  <= ADDR1;
                    end
                end
                ADDR1: state_q <= ADDR2;
                ADDR2: state_q <= ADDR3;
                ADDR3: state_q <= ADDR4;
                ADDR4: state_q <= CMD;
                CMD:   state_q <= GUARD;
                GUARD: state_q <= WAIT_CMD;
                WAIT_CMD: begin
                    if (!drive_busy) begin
                        state_q <= DATA;
                    end else if (expired) begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        bcnt_q  <= bcnt_q + 10'd1;
                        state_q <= WAIT_BYTE;
                    end
                end
                WAIT_BYTE: begin
                    if (!drive_busy) begin
                        state_q <= (bcnt_q == BB_N) ? NEXT : DATA;
                    end else if (expired) begin
                        state_q <= IDLE;
                    end
                end
                NEXT: begin
                    lba_q    <= lba_q + 32'd1;
                    remain_q <= remain_q - 9'd1;
                    bcnt_q   <= '0;
                    state_q  <= (remain_q == 9'd1) ? FINISH : ADDR1;
                end
                FINISH:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode; the bus is zero unless a strobe is driving it.
    always_comb begin
        req_ready             = 1'b0;
        internal_data_bus     = 8'h00;
        write_block_address_1 = 1'b0;
        write_block_address_2 = 1'b0;
        write_block_address_3 = 1'b0;
        write_block_address_4 = 1'b0;
        write_access_command  = 1'b0;
        write_data            = 1'b0;
        read_data_strobe      = 1'b0;
        terminal_count        = 1'b0;
        rd_data               = 8'h00;
        rd_valid              = 1'b0;
        wr_ready              = 1'b0;
        done                  = 1'b0;
        error                 = 1'b0;
        unique case (state_q)
            IDLE: req_ready = 1'b1;
            ADDR1: begin
                write_block_address_1 = 1'b1;
                internal_data_bus     = lba_q[7:0];
            end
            ADDR2: begin
                write_block_address_2 = 1'b1;
                internal_data_bus     = lba_q[15:8];
            end
            ADDR3: begin
                write_block_address_3 = 1'b1;
                internal_data_bus     = lba_q[23:16];
            end
            ADDR4: begin
                write_block_address_4 = 1'b1;
                internal_data_bus     = lba_q[31:24];
            end
            CMD: begin
                write_access_command = 1'b1;
                internal_data_bus    = write_q ? write_command : read_command;
            end
            WAIT_CMD, WAIT_BYTE: error = drive_busy && expired;
            DATA: begin
                terminal_count = xfer && last_byte;
                if (write_q) begin
                    wr_ready   = 1'b1;
                    write_data = wr_valid;
                    if (wr_valid) begin
                        internal_data_bus = wr_data;
                    end
                end else begin
                    rd_valid         = 1'b1;
                    rd_data          = read_data;
                    read_data_strobe = rd_ready;
                end
            end
            FINISH: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_kfmmc_block_sequencer.sv
// Scoreboard bench for kfmmc_block_sequencer with random drive timing.
// Expected strobe/byte events are queued per request and popped by a monitor.
module tb_kfmmc_block_sequencer;

    localparam int BB  = 32;
    localparam int TMO = 100;

    logic        clock, reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_lba;
    logic [7:0]  req_count;
    logic [7:0]  internal_data_bus;
    logic        wba1, wba2, wba3, wba4;
    logic        write_access_command, write_data, read_data_strobe;
    logic [7:0]  read_data;
    logic        drive_busy, terminal_count;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_ready;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready, done, error;

    kfmmc_block_sequencer #(
        .block_bytes  (BB),
        .read_command (8'h80),
        .write_command(8'h81),
        .busy_timeout (32'(TMO))
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_write            (req_write),
        .req_lba              (req_lba),
        .req_count            (req_count),
        .internal_data_bus    (internal_data_bus),
        .write_block_address_1(wba1),
        .write_block_address_2(wba2),
        .write_block_address_3(wba3),
        .write_block_address_4(wba4),
        .write_access_command (write_access_command),
        .write_data           (write_data),
        .read_data_strobe     (read_data_strobe),
        .read_data            (read_data),
        .drive_busy           (drive_busy),
        .terminal_count       (terminal_count),
        .rd_data              (rd_data),
        .rd_valid             (rd_valid),
        .rd_ready             (rd_ready),
        .wr_data              (wr_data),
        .wr_valid             (wr_valid),
        .wr_ready             (wr_ready),
        .done                 (done),
        .error                (error)
    );

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       tc;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0, n_pass = 0;
    int  busy_mode = 0, rd_mode = 0, wr_mode = 0;
    bit  aborting = 0, want_ready = 0;
    int  rptr = 0, wptr = 0, seed_r = 0, seed_w = 0;
    int  cyc = 0, last_cmd_cyc = 0, n_rstb = 0;

    assign read_data = 8'(rptr * 7 + seed_r);
    assign wr_data   = 8'(wptr * 13 + seed_w + 5);

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, req);
    endtask

    function automatic void push(int k, logic [7:0] d, logic t);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.tc   = t;
        exp_q.push_back(e);
    endfunction

    function automatic bit is_idle();
        return req_ready && !(|{internal_data_bus, wba1, wba2, wba3, wba4,
            write_access_command, write_data, read_data_strobe,
            terminal_count, rd_data, rd_valid, wr_ready, done, error});
    endfunction

    task automatic take(input int k, input logic [7:0] d, input logic t);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk(0, "unexpected_event", 32'(k), 0);
        end else begin
            e = exp_q.pop_front();
            chk(e.kind == k && e.data == d && e.tc == t, "event",
                (32'(k) << 16) | (32'(d) << 8) | 32'(t),
                (32'(e.kind) << 16) | (32'(e.data) << 8) | 32'(e.tc));
        end
    endtask

    // Input driver: drive timing and handshake patterns.
    always @(posedge clock) begin
        #1;
        case (busy_mode)
            0: drive_busy = 1'b0;
            1: drive_busy = ($urandom_range(0, 9) < 3);
            default: drive_busy = 1'b1;
        endcase
        case (rd_mode)
            0: rd_ready = 1'b1;
            1: rd_ready = ~rd_ready;
            default: rd_ready = 1'($urandom_range(0, 1));
        endcase
        wr_valid = (wr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Monitor: per-cycle invariants and event scoreboard.
    always @(negedge clock) begin
        int ns;
        cyc++;
        if (want_ready) begin
            want_ready = 0;
            chk(req_ready == 1'b1, "ready_after_error", 32'(req_ready), 1);
        end
        if (!aborting && !reset) begin
            ns = int'(wba1) + int'(wba2) + int'(wba3) + int'(wba4) +
                 int'(write_access_command) + int'(write_data) +
                 int'(read_data_strobe);
            chk(ns <= 1 && (ns != 0 || internal_data_bus == 8'h00) &&
                (!terminal_count || write_data || read_data_strobe) &&
                ((rd_valid && rd_ready) == read_data_strobe),
                "strobes", {16'(ns), internal_data_bus, 7'd0, terminal_count},
                32'h00010000);
            if (wba1) take(1, internal_data_bus, terminal_count);
            if (wba2) take(2, internal_data_bus, terminal_count);
            if (wba3) take(3, internal_data_bus, terminal_count);
            if (wba4) take(4, internal_data_bus, terminal_count);
            if (write_access_command) begin
                last_cmd_cyc = cyc;
                take(5, internal_data_bus, terminal_count);
            end
            if (read_data_strobe) begin
                take(6, rd_data, terminal_count);
                n_rstb++;
                rptr++;
            end
            if (write_data) begin
                take(7, internal_data_bus, terminal_count);
                wptr++;
            end
            if (done) take(8, 8'h00, 1'b0);
            if (error) begin
                take(9, 8'h00, 1'b0);
                chk(cyc - last_cmd_cyc == TMO + 2, "error_timing",
                    32'(cyc - last_cmd_cyc), 32'(TMO + 2));
                want_ready = 1;
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #1;
        aborting = 1;
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0;
        @(negedge clock);
        chk(is_idle(), "idle_after_reset", 32'(req_ready), 1);
        exp_q.delete();
        rptr = 0;
        wptr = 0;
        aborting = 0;
    endtask

    task automatic issue(input bit w, input logic [31:0] lba,
                         input logic [7:0] cnt, input bit tmo);
        int nb;
        nb = (cnt == 0) ? 256 : int'(cnt);
        seed_r = int'($urandom_range(0, 255));
        seed_w = int'($urandom_range(0, 255));
        rptr = 0;
        wptr = 0;
        n_rstb = 0;
        for (int b = 0; b < nb; b++) begin
            logic [31:0] a;
            a = lba + 32'(b);
            for (int n = 0; n < 4; n++) push(n + 1, a[8*n +: 8], 1'b0);
            push(5, w ? 8'h81 : 8'h80, 1'b0);
            if (tmo) begin
                push(9, 8'h00, 1'b0);
            end else begin
                for (int i = 0; i < BB; i++) begin
                    int k;
                    k = b * BB + i;
                    push(w ? 7 : 6,
                         w ? 8'(k * 13 + seed_w + 5) : 8'(k * 7 + seed_r),
                         (b == nb - 1) && (i == BB - 1));
                end
            end
        end
        if (!tmo) push(8, 8'h00, 1'b0);
        @(posedge clock);
        #1;
        req_valid = 1;
        req_write = w;
        req_lba   = lba;
        req_count = cnt;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (req_ready) break;
        end
        chk(req_ready == 1'b1, "accept", 32'(req_ready), 1);
        @(posedge clock);
        #1;
        req_valid = 0;
        req_write = 1'($urandom_range(0, 1));
        req_lba   = $urandom;
        req_count = 8'($urandom);
    endtask

    task automatic wait_done(input int bud);
        for (int c = 0; c < bud; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        chk(exp_q.size() == 0, "complete", 32'(exp_q.size()), 0);
        if (exp_q.size() != 0) do_reset();
        repeat (3) @(negedge clock);
    endtask

    task automatic run(input bit w, input logic [31:0] lba,
                       input logic [7:0] cnt, input int bm, input int rm);
        int nb;
        nb = (cnt == 0) ? 256 : int'(cnt);
        busy_mode = bm;
        rd_mode   = rm;
        wr_mode   = int'($urandom_range(0, 1));
        issue(w, lba, cnt, 1'b0);
        wait_done(nb * (BB * 12 + 60) + 200);
        if (!w) chk(n_rstb == nb * BB, "read_strobe_count",
                    32'(n_rstb), 32'(nb * BB));
    endtask

    initial begin
        reset = 1;
        req_valid = 0;
        req_write = 0;
        req_lba = 0;
        req_count = 0;
        drive_busy = 0;
        rd_ready = 0;
        wr_valid = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk(is_idle(), "reset_state", 32'(req_ready), 1);
        #1;
        reset = 0;
        repeat (2) @(negedge clock);

        run(1'b0, 32'h00000010, 8'd1, 1, 0);
        run(1'b1, 32'hFFFFFFFF, 8'd2, 1, 0);
        run(1'b0, 32'h12345678, 8'd1, 1, 1);

        busy_mode = 2;
        issue(1'b0, 32'hA5A50001, 8'd1, 1'b1);
        wait_done(TMO + 60);
        busy_mode = 0;

        busy_mode = 1;
        rd_mode = 2;
        issue(1'b0, 32'h00C0FFEE, 8'd8, 1'b0);
        for (int c = 0; c < 20000; c++) begin
            @(negedge clock);
            if (rptr >= 200) break;
        end
        chk(rptr >= 200, "reach_byte_200", 32'(rptr), 200);
        do_reset();
        run(1'b1, 32'h0000ABCD, 8'd3, 1, 0);

        run(1'b0, 32'hFFFFFF80, 8'd0, 0, 0);

        for (int t = 0; t < 4; t++) begin
            run(1'($urandom_range(0, 1)), $urandom,
                8'($urandom_range(1, 3)), 1, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
